dir_queue: RTL
==============

# dir_queue

Direction-command buffer for the snake game, directly downstream of the per-button synchronizer/edge-detector stages. It takes four one-cycle press pulses (up, down, left, right) and filters out illegal turns (reversal, repeat). It queues up to DEPTH pending turns and releases one turn per game move tick, so fast double-taps between ticks are not lost. The registered direction output feeds the snake movement/body-update logic.

## Interface
- DEPTH, 4: pending-turn queue capacity; power of two, ≥2.
- INIT_DIR, 2'b11: direction after reset/clear.
- Direction encoding: UP=2'b00, DOWN=2'b01, LEFT=2'b10, RIGHT=2'b11. The opposite of d is {d[1], ~d[0]}.

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  reset nrst, asynchronous, active-low.
- up_p  in  1  one-cycle press pulse, up button.
- down_p  in  1  one-cycle press pulse, down button.
- left_p  in  1  one-cycle press pulse, left button.
- right_p  in  1  one-cycle press pulse, right button.
- move_tick  in  1  one-cycle strobe; the snake advances one cell this cycle.
- clear  in  1  synchronous restart (new game).
- dir  out  2  current committed direction, registered.
- next_dir  out  2  direction the next tick will commit: queue head if non-empty, else dir.
- count  out  $clog2(DEPTH+1)  number of queued turns.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- overflow  out  1  sticky; a legal turn was dropped because the queue was full.

## Operation
- Candidate select: when several pulses are high in one cycle, priority is up > down > left > right. Only the winner is considered; the others are discarded silently.
- Reference direction ref_dir = last enqueued entry (tail) if the queue is non-empty, else dir. Evaluate it using pre-edge register values.
- Accept when the candidate is present, candidate != ref_dir, and candidate != opposite(ref_dir).
- Reject (no state change) when the candidate equals ref_dir or its opposite.
- If accepted and the queue is full with no pop this cycle, drop the candidate and set overflow.
- Pop: on move_tick with the queue non-empty, set dir <= head and remove the head. On move_tick with the queue empty, dir is unchanged.
- Simultaneous push and pop are both performed and count is unchanged. When the queue is full, a pop in the same cycle frees a slot, so the push succeeds and overflow is not set.
- Push into an empty queue in the same cycle as move_tick: the tick pops nothing, the candidate is enqueued (checked against dir) and is committed on the following tick.
- clear has priority over everything in that cycle: count=0, dir=INIT_DIR, overflow=0, pulses and tick ignored.
- Storage is a circular buffer with rd/wr pointers of width $clog2(DEPTH) that wrap naturally. The separate count register is the authority for full/empty.
- overflow is cleared only by nrst or clear.

## Timing
- Reset values (async, nrst low): dir=INIT_DIR, next_dir=INIT_DIR, count=0, empty=1, full=0, overflow=0, pointers=0.
- dir, count, overflow and pointers are registered. empty, full and next_dir are combinational from registers only, with no input-to-output paths.
- Latency:
  - Pulse at edge N is reflected in count/next_dir after edge N.
  - An accepted turn becomes dir at the first move_tick strictly after the push cycle.
  - Minimum turn latency is 1 cycle (push at N, tick at N+1 → dir valid after edge N+1).
- Back-to-back pulses on consecutive cycles are each evaluated against the updated tail.
- Asserting nrst mid-operation discards queued turns immediately.

## Test plan
- Reset, then no input for 10 cycles with ticks → dir=2'b11, count=0, empty=1, overflow=0.
- dir=RIGHT, left_p pulse, then right_p pulse, then tick → both rejected, count=0, dir stays 2'b11.
- dir=RIGHT, up_p at cycle 1, left_p at cycle 2, tick at cycles 5 and 9 → count=2; dir=UP after tick 1; dir=LEFT after tick 2; empty=1.
- DEPTH=4, alternating up/left/down/right legal sequence of 5 pulses with no tick → count=4, full=1, overflow=1 after the 5th. Repeat with a tick on the 5th pulse cycle → count=4, overflow=0.
- up_p and right_p high in the same cycle while dir=RIGHT → up enqueued, right ignored, count=1.
- Queue holding 3 entries, clear asserted together with up_p and move_tick → count=0, dir=2'b11, overflow=0. Also assert nrst mid-sequence → all outputs at reset values immediately.

Source files
------------

// File: rtl/dir_queue_if.sv
// dir_queue_if: command/status bundle for the snake direction queue.
//   master: drives the button press pulses, move_tick and clear; observes status.
//   slave : the dir_queue itself; consumes the commands and drives
//           dir, next_dir, count, empty, full and overflow.
interface dir_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic          up_p;
  logic          down_p;
  logic          left_p;
  logic          right_p;
  logic          move_tick;
  logic          clear;
  logic [1:0]    dir;
  logic [1:0]    next_dir;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          overflow;

  modport master (
    output up_p, down_p, left_p, right_p, move_tick, clear,
    input  dir, next_dir, count, empty, full, overflow
  );

  modport slave (
    input  up_p, down_p, left_p, right_p, move_tick, clear,
    output dir, next_dir, count, empty, full, overflow
  );
endinterface

// File: rtl/dir_queue.sv
// dir_queue: direction-command buffer for the snake game.
// Takes one-cycle press pulses (up > down > left > right priority), rejects
// repeats and reversals relative to the most recent queued turn (or the
// committed direction when nothing is queued), buffers up to DEPTH turns and
// commits one per move_tick.
// Ports:
//   clk   - system clock, rising edge
//   nrst  - asynchronous active-low reset
//   bus   - dir_queue_if slave: press pulses, move_tick, clear in;
//           dir (registered), next_dir, count, empty, full, overflow (sticky) out
module dir_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [1:0]  INIT_DIR = 2'b11
) (
  input logic        clk,
  input logic        nrst,
  dir_queue_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    UP    = 2'b00,
    DOWN  = 2'b01,
    LEFT  = 2'b10,
    RIGHT = 2'b11
  } dir_t;

  logic [1:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic [1:0]    dir_q;
  logic          ovf;

  logic          is_empty;
  logic          is_full;
  logic          cand_vld;
  dir_t          cand;
  logic [1:0]    tail;
  logic [1:0]    ref_dir;
  logic          legal;
  logic          pop;
  logic          push;
  logic          drop;

  always_comb begin
    is_empty = (cnt == '0);
    is_full  = (cnt == CW'(DEPTH));
    // Most recently enqueued entry sits one slot behind the write pointer.
    tail     = mem[wr_ptr - PW'(1)];
    ref_dir  = is_empty ? dir_q : tail;

    cand_vld = 1'b1;
    cand     = RIGHT;
    if (bus.up_p)          cand = UP;
    else if (bus.down_p)   cand = DOWN;
    else if (bus.left_p)   cand = LEFT;
    else if (bus.right_p)  cand = RIGHT;
    else                   cand_vld = 1'b0;

    // Opposite direction differs only in bit 0.
    legal = cand_vld
          && (2'(cand) != ref_dir)
          && (2'(cand) != {ref_dir[1], ~ref_dir[0]});

    pop  = bus.move_tick && !is_empty;
    // A pop in the same cycle frees a slot, so a full queue still accepts.
    push = legal && (!is_full || pop);
    drop = legal && is_full && !pop;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      dir_q  <= INIT_DIR;
      ovf    <= 1'b0;
    end else if (bus.clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      dir_q  <= INIT_DIR;
      ovf    <= 1'b0;
    end else begin
      if (pop) begin
        dir_q  <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (push && !pop) begin
        cnt <= cnt + CW'(1);
      end else if (pop && !push) begin
        cnt <= cnt - CW'(1);
      end
      if (drop) begin
        ovf <= 1'b1;
      end
    end
  end

  // Storage needs no reset: slots are only read when count says they are valid.
  always_ff @(posedge clk) begin
    if (push && !bus.clear) begin
      mem[wr_ptr] <= 2'(cand);
    end
  end

  always_comb begin
    bus.dir      = dir_q;
    bus.next_dir = is_empty ? dir_q : mem[rd_ptr];
    bus.count    = cnt;
    bus.empty    = is_empty;
    bus.full     = is_full;
    bus.overflow = ovf;
  end
endmodule
